// File: rtl/regfile_sb.sv
// Integer register file with N combinational read ports, write-first bypass,
// asynchronous clear and a pending-write scoreboard for RAW hazard detection.
module regfile_sb #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter int NRP     = 2,
   parameter int DBG_IDX = 5,
   parameter int DBG_W   = 24
) (
   input  logic                     clk_I,
   input  logic                     rst_n_I,
   input  logic                     r_en_I,
   input  logic [NRP*$clog2(NREGS)-1:0] raddr_I,
   output logic [NRP*XLEN-1:0]      rdata_O,
   output logic [NRP-1:0]           hazard_O,
   input  logic                     w_en_I,
   input  logic [$clog2(NREGS)-1:0] waddr_I,
   input  logic [XLEN-1:0]          wdata_I,
   input  logic                     issue_en_I,
   input  logic [$clog2(NREGS)-1:0] issue_rd_I,
   input  logic                     flush_I,
   output logic [NREGS-1:0]         busy_O,
   output logic [DBG_W-1:0]         dbg_O
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy_reg;
   logic [NREGS-1:0] busy_next;

   // x0 is cleared by reset and never written, so it always reads as zero.
   always_ff @(posedge clk_I or negedge rst_n_I) begin
      if (!rst_n_I) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (w_en_I && (waddr_I != '0)) begin
         regs[waddr_I] <= wdata_I;
      end
   end

   // Issue is applied after writeback so a newer producer keeps the bit set.
   always_comb begin
      busy_next = busy_reg;
      if (w_en_I) begin
         busy_next[waddr_I] = 1'b0;
      end
      if (issue_en_I && (issue_rd_I != '0)) begin
         busy_next[issue_rd_I] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk_I or negedge rst_n_I) begin
      if (!rst_n_I) begin
         busy_reg <= '0;
      end else if (flush_I) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NRP; gi++) begin : g_rport
         logic [AW-1:0] addr;
         logic          bypass;

         assign addr   = raddr_I[gi*AW +: AW];
         assign bypass = w_en_I && (waddr_I == addr);

         always_comb begin
            rdata_O[gi*XLEN +: XLEN] = '0;
            if (r_en_I && (addr != '0)) begin
               rdata_O[gi*XLEN +: XLEN] = bypass ? wdata_I : regs[addr];
            end
         end

         assign hazard_O[gi] = r_en_I && (addr != '0) && busy_reg[addr] && !bypass;
      end
   endgenerate

   assign busy_O = busy_reg;
   assign dbg_O  = regs[DBG_IDX][DBG_W-1:0];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a per-cycle scoreboard model check on the default
// configuration, hand-computed directed checks, and a 4-port/16-bit instance.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r_en;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  hazard;
   logic        w_en;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic        flush;
   logic [31:0] busy;
   logic [23:0] dbg;

   logic        r_en4;
   logic [19:0] raddr4;
   logic [63:0] rdata4;
   logic [3:0]  hazard4;
   logic        w_en4;
   logic [4:0]  waddr4;
   logic [15:0] wdata4;
   logic [31:0] busy4;
   logic [15:0] dbg4;
   logic        issue_en4 = 1'b0;
   logic [4:0]  issue_rd4 = 5'd0;
   logic        flush4 = 1'b0;

   int n_checks = 0;
   int n_fails  = 0;
   bit chk_en   = 1'b0;

   logic [31:0] m_regs [32];
   bit          m_busy [32];

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk_I(clk), .rst_n_I(rst_n), .r_en_I(r_en), .raddr_I(raddr),
      .rdata_O(rdata), .hazard_O(hazard), .w_en_I(w_en), .waddr_I(waddr),
      .wdata_I(wdata), .issue_en_I(issue_en), .issue_rd_I(issue_rd),
      .flush_I(flush), .busy_O(busy), .dbg_O(dbg)
   );

   regfile_sb #(.XLEN(16), .NREGS(32), .NRP(4), .DBG_IDX(2), .DBG_W(16)) dut4 (
      .clk_I(clk), .rst_n_I(rst_n), .r_en_I(r_en4), .raddr_I(raddr4),
      .rdata_O(rdata4), .hazard_O(hazard4), .w_en_I(w_en4), .waddr_I(waddr4),
      .wdata_I(wdata4), .issue_en_I(issue_en4), .issue_rd_I(issue_rd4),
      .flush_I(flush4), .busy_O(busy4), .dbg_O(dbg4)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural state follows the rules: writes to x0 dropped, flush wins, set after clear.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] <= 32'd0;
            m_busy[i] <= 1'b0;
         end
      end else begin
         if (w_en && waddr != 0) m_regs[waddr] <= wdata;
         if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
         end else begin
            if (w_en) m_busy[waddr] <= 1'b0;
            if (issue_en && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         logic [31:0] exp_bv;
         for (int p = 0; p < 2; p++) begin
            logic [4:0]  a;
            logic [31:0] erd;
            logic        ehz;
            a   = raddr[p*5 +: 5];
            erd = 32'd0;
            if (r_en && a != 0) erd = (w_en && waddr == a) ? wdata : m_regs[a];
            ehz = r_en && a != 0 && m_busy[a] && !(w_en && waddr == a);
            check($sformatf("model_rdata%0d", p), {32'd0, rdata[p*32 +: 32]}, {32'd0, erd});
            check($sformatf("model_hazard%0d", p), {63'd0, hazard[p]}, {63'd0, ehz});
         end
         for (int i = 0; i < 32; i++) exp_bv[i] = m_busy[i];
         check("model_busy", {32'd0, busy}, {32'd0, exp_bv});
         check("model_dbg", {40'd0, dbg}, {40'd0, m_regs[5][23:0]});
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      w_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; r_en = 1'b0; raddr = '0; w_en = 1'b0; waddr = '0; wdata = '0;
      issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
      r_en4 = 1'b0; raddr4 = '0; w_en4 = 1'b0; waddr4 = '0; wdata4 = '0;
      #8;
      r_en = 1'b1; raddr = {5'd1, 5'd5};
      #1;
      check("reset_rdata", rdata, 64'd0);
      check("reset_busy", {32'd0, busy}, 64'd0);
      check("reset_hazard", {62'd0, hazard}, 64'd0);
      check("reset_dbg", {40'd0, dbg}, 64'd0);
      next_cycle();
      rst_n = 1'b1;
      chk_en = 1'b1;
      next_cycle();

      // Reset mid-operation clears x5 immediately
      w_en = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
      #3 check("x5_bypass", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
      next_cycle();
      idle();
      #1 check("x5_stored", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
      check("dbg_x5", {40'd0, dbg}, 64'hADBEEF);
      #1 rst_n = 1'b0;
      #1 check("x5_after_rst", {32'd0, rdata[31:0]}, 64'd0);
      check("dbg_after_rst", {40'd0, dbg}, 64'd0);
      #1 rst_n = 1'b1;
      next_cycle();

      // Bypass on port 1
      w_en = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr = {5'd7, 5'd5};
      #3 check("x7_bypass_p1", {32'd0, rdata[63:32]}, 64'h12345678);
      check("x5_still_zero", {32'd0, rdata[31:0]}, 64'd0);
      next_cycle();
      idle();
      #3 check("x7_stored_p1", {32'd0, rdata[63:32]}, 64'h12345678);
      next_cycle();

      // x0 is immune to writes and issue
      w_en = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; issue_en = 1'b1; issue_rd = 5'd0;
      raddr = {5'd0, 5'd0};
      #3 check("x0_bypass_blocked", rdata, 64'd0);
      next_cycle();
      idle();
      #3 check("x0_read", rdata, 64'd0);
      check("x0_busy", {63'd0, busy[0]}, 64'd0);
      check("x0_hazard", {62'd0, hazard}, 64'd0);
      next_cycle();

      // Scoreboard set/clear on x3
      issue_en = 1'b1; issue_rd = 5'd3;
      next_cycle();
      idle(); raddr = {5'd0, 5'd3};
      #3 check("x3_busy_set", {63'd0, busy[3]}, 64'd1);
      check("x3_hazard", {62'd0, hazard}, 64'd1);
      next_cycle();
      w_en = 1'b1; waddr = 5'd3; wdata = 32'h33;
      #3 check("x3_wb_hazard", {62'd0, hazard}, 64'd0);
      check("x3_wb_bypass", {32'd0, rdata[31:0]}, 64'h33);
      next_cycle();
      idle();
      #3 check("x3_busy_clr", {63'd0, busy[3]}, 64'd0);
      next_cycle();
      issue_en = 1'b1; issue_rd = 5'd3; w_en = 1'b1; waddr = 5'd3; wdata = 32'h44;
      next_cycle();
      idle();
      #3 check("x3_set_wins", {63'd0, busy[3]}, 64'd1);
      check("x3_new_value", {32'd0, rdata[31:0]}, 64'h44);
      next_cycle();

      // Flush clears everything, ignores same-cycle issue, keeps the write
      issue_en = 1'b1; issue_rd = 5'd4; next_cycle();
      issue_rd = 5'd6; next_cycle();
      issue_rd = 5'd9; next_cycle();
      #3 check("busy_pre_flush", {32'd0, busy}, 64'h258);
      flush = 1'b1; issue_rd = 5'd10; w_en = 1'b1; waddr = 5'd9; wdata = 32'h99;
      next_cycle();
      idle(); raddr = {5'd10, 5'd9};
      #3 check("busy_post_flush", {32'd0, busy}, 64'd0);
      check("flush_write_kept", {32'd0, rdata[31:0]}, 64'h99);
      next_cycle();

      // r_en low forces zero on all lanes
      r_en = 1'b0; raddr = {5'd9, 5'd7};
      #3 check("ren_low", rdata, 64'd0);
      next_cycle();
      r_en = 1'b1;

      // Directed-but-varied traffic for the model checker
      for (int i = 0; i < 48; i++) begin
         w_en     = $urandom_range(0, 1);
         waddr    = 5'($urandom_range(0, 7));
         wdata    = $urandom;
         issue_en = $urandom_range(0, 1);
         issue_rd = 5'($urandom_range(0, 7));
         flush    = ($urandom_range(0, 9) == 0);
         r_en     = ($urandom_range(0, 7) != 0);
         raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         next_cycle();
      end
      idle();

      // Four-port, 16-bit instance
      w_en4 = 1'b1; waddr4 = 5'd1; wdata4 = 16'h00AA; next_cycle();
      waddr4 = 5'd2; wdata4 = 16'h00BB; next_cycle();
      w_en4 = 1'b0; r_en4 = 1'b1; raddr4 = {5'd0, 5'd2, 5'd1, 5'd1};
      #3 check("mp_lanes", rdata4, 64'h0000_00BB_00AA_00AA);
      check("mp_dbg", {48'd0, dbg4}, 64'h00BB);
      check("mp_hazard", {60'd0, hazard4}, 64'd0);
      next_cycle();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
